// File: rtl/mem_copy_pkg.sv
// Shared types and default sizes for the on-chip memory copy engine.
package mem_copy_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_LEN_W  = 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/onchip_mem_copier_if.sv
// Avalon-MM slave-port bundle (zero-wait, read latency 1) between the copier and the memory.
interface onchip_mem_copier_if
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_mem_copier.sv
// Word-by-word copy engine: READ -> LATCH -> WRITE per word, start/busy/done control.
// Optional MEM_COPY_FILL_EN adds a fill mode that writes a constant word without reading.
module onchip_mem_copier
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W  = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
`endif
  output logic              busy,
  output logic              done,
  onchip_mem_copier_if.master bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  idx_reg, idx_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              fill_mode;
`ifdef MEM_COPY_FILL_EN
  logic              fill_reg, fill_next;
  logic [DATA_W-1:0] fill_data_reg, fill_data_next;
  assign fill_mode = fill_reg;
`else
  assign fill_mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
      data_reg      <= '0;
`ifdef MEM_COPY_FILL_EN
      fill_reg      <= 1'b0;
      fill_data_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
      data_reg      <= data_next;
`ifdef MEM_COPY_FILL_EN
      fill_reg      <= fill_next;
      fill_data_reg <= fill_data_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    data_next      = data_reg;
`ifdef MEM_COPY_FILL_EN
    fill_next      = fill_reg;
    fill_data_next = fill_data_reg;
`endif
    case (state_reg)
      IDLE: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          src_next = src_addr;
          dst_next = dst_addr;
          len_next = length;
          idx_next = '0;
`ifdef MEM_COPY_FILL_EN
          fill_next      = fill;
          fill_data_next = fill_data;
          if (length == '0)
            state_next = DONE;
          else if (fill)
            state_next = WRITE;
          else
            state_next = READ;
`else
          state_next = (length == '0) ? DONE : READ;
`endif
        end
      end
      READ:  state_next = LATCH;
      LATCH: begin
        data_next  = bus.readdata;
        state_next = WRITE;
      end
      WRITE: begin
        idx_next = idx_reg + LEN_W'(1);
        if (idx_next == len_reg)
          state_next = DONE;
        else if (fill_mode)
          state_next = WRITE;
        else
          state_next = READ;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (abort && state_reg != IDLE)
      state_next = IDLE;
  end

  // Bus outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    bus.address   = '0;
    bus.writedata = '0;
    case (state_reg)
      READ:  bus.address = src_reg + idx_reg[ADDR_W-1:0];
      WRITE: begin
        bus.address   = dst_reg + idx_reg[ADDR_W-1:0];
`ifdef MEM_COPY_FILL_EN
        bus.writedata = fill_reg ? fill_data_reg : data_reg;
`else
        bus.writedata = data_reg;
`endif
      end
      default: ;
    endcase
  end

  assign bus.chipselect = (state_reg == READ) || (state_reg == WRITE);
  assign bus.write      = (state_reg == WRITE);
  assign bus.byteenable = '1;
  assign bus.clken      = 1'b1;
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);

endmodule

// File: tb/tb_onchip_mem_copier.sv
// Self-checking bench for onchip_mem_copier with a behavioural memory slave and array model.
module tb_onchip_mem_copier;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 13;
  localparam int MEM_WORDS = 4096;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy;
  logic          done;
`ifdef MEM_COPY_FILL_EN
  logic          fill = 1'b0;
  logic [DW-1:0] fill_data = '0;
`endif

  onchip_mem_copier_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  onchip_mem_copier #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
`ifdef MEM_COPY_FILL_EN
    .fill     (fill),
    .fill_data(fill_data),
`endif
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Memory slave: registered address, unregistered read output.
  logic [DW-1:0] mem [MEM_WORDS];
  logic [AW-1:0] rd_addr_q = '0;
  logic          preload = 1'b0;
  int            wr_total = 0;
  int            rd_total = 0;
  int            done_total = 0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_WORDS; i++)
        mem[i] <= (i >= 16 && i < 20) ? DW'(32'hA0 + i - 16) : $urandom;
    end else if (bus.clken && bus.chipselect) begin
      if (bus.write) begin
        mem[bus.address] <= bus.writedata;
        wr_total <= wr_total + 1;
      end else begin
        rd_addr_q <= bus.address;
        rd_total <= rd_total + 1;
      end
    end
    if (done) done_total <= done_total + 1;
  end
  assign bus.readdata = mem[rd_addr_q];

  logic [DW-1:0] model [MEM_WORDS];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic snap_model();
    for (int i = 0; i < MEM_WORDS; i++) model[i] = mem[i];
  endtask

  // Reference: ascending word-at-a-time copy (or fill) with modulo-2^AW addressing.
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int n, input logic f, input logic [DW-1:0] fd);
    for (int j = 0; j < n; j++) begin
      logic [AW-1:0] sa, da;
      sa = s + AW'(j);
      da = d + AW'(j);
      model[da] = f ? fd : model[sa];
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++)
      if (mem[i] !== model[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                          output int done_cyc, output int busy_cyc,
                          output int nwr, output int nrd, output int ndone);
    int w0, r0, d0, c;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    w0 = wr_total;
    r0 = rd_total;
    d0 = done_total;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    length   = LW'($urandom);
    done_cyc = 0;
    busy_cyc = 0;
    c = 1;
    while (busy && c <= 20000) begin
      if (done && done_cyc == 0) done_cyc = c;
      busy_cyc++;
      @(negedge clk);
      c++;
    end
    check("run_timeout", {63'b0, busy}, 64'd0);
    nwr   = wr_total - w0;
    nrd   = rd_total - r0;
    ndone = done_total - d0;
    $display("copy src=%03h dst=%03h len=%0d done_at=%0d busy=%0d wr=%0d rd=%0d",
             s, d, n, done_cyc, busy_cyc, nwr, nrd);
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    int            exp_cyc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, bc, nw, nr, nd, w0, d0, cnt, exp_cyc;
    logic          f;
    logic [DW-1:0] fd;
    logic [AW-1:0] s, d;
    logic [LW-1:0] n;

    vecs[0] = '{12'h010, 12'h100, 13'd4, 13};
    vecs[1] = '{12'h123, 12'h456, 13'd0, 1};
    vecs[2] = '{12'hFFE, 12'h200, 13'd4, 13};
    vecs[3] = '{12'h050, 12'h051, 13'd1, 4};
    vecs[4] = '{12'h400, 12'h402, 13'd6, 19};

    preload = 1'b1;
    repeat (2) @(negedge clk);
    preload = 1'b0;

    check("rst_busy", {63'b0, busy}, 0);
    check("rst_done", {63'b0, done}, 0);
    check("rst_cs", {63'b0, bus.chipselect}, 0);
    check("rst_write", {63'b0, bus.write}, 0);
    check("rst_addr", 64'(bus.address), 0);
    check("rst_wdata", 64'(bus.writedata), 0);
    check("rst_be", 64'(bus.byteenable), 64'hF);
    check("rst_clken", {63'b0, bus.clken}, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // start and abort together in IDLE: stay idle, no bus traffic
    @(negedge clk);
    w0 = wr_total + rd_total;
    length = 13'd4;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", {63'b0, busy}, 0);
    repeat (3) @(negedge clk);
    check("idle_abort_bus", wr_total + rd_total - w0, 0);
    $display("idle start+abort busy=%0d", busy);

    for (int v = 0; v < 5; v++) begin
      snap_model();
      model_copy(vecs[v].src, vecs[v].dst, int'(vecs[v].len), 1'b0, '0);
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, dc, bc, nw, nr, nd);
      check($sformatf("vec%0d_done_cyc", v), dc, vecs[v].exp_cyc);
      check($sformatf("vec%0d_busy_cyc", v), bc, vecs[v].exp_cyc);
      check($sformatf("vec%0d_writes", v), nw, int'(vecs[v].len));
      check($sformatf("vec%0d_reads", v), nr, int'(vecs[v].len));
      check($sformatf("vec%0d_done_cnt", v), nd, 1);
      check_mem($sformatf("vec%0d_mem", v));
      if (v == 0)
        for (int j = 0; j < 4; j++)
          check($sformatf("basic_word%0d", j), 64'(mem[12'h100 + j]), 64'hA0 + j);
    end

    // Abort during LATCH of word 3 (cycle 8 after the start edge)
    snap_model();
    model_copy(12'h600, 12'h700, 2, 1'b0, '0);
    @(negedge clk);
    src_addr = 12'h600;
    dst_addr = 12'h700;
    length   = 13'd8;
    start    = 1'b1;
    w0 = wr_total;
    d0 = done_total;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_next", {63'b0, busy}, 0);
    check("abort_writes", wr_total - w0, 2);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_total - d0, 0);
    check_mem("abort_mem");
    $display("abort after %0d writes", wr_total - w0);
    snap_model();
    model_copy(12'h610, 12'h710, 3, 1'b0, '0);
    run_copy(12'h610, 12'h710, 13'd3, dc, bc, nw, nr, nd);
    check("restart_done_cyc", dc, 10);
    check_mem("restart_mem");

`ifdef MEM_COPY_FILL_EN
    snap_model();
    model_copy(12'h300, 12'h300, 5, 1'b1, 32'hDEADBEEF);
    fill = 1'b1;
    fill_data = 32'hDEADBEEF;
    run_copy(12'h000, 12'h300, 13'd5, dc, bc, nw, nr, nd);
    fill = 1'b0;
    check("fill_done_cyc", dc, 6);
    check("fill_reads", nr, 0);
    check("fill_writes", nw, 5);
    check_mem("fill_mem");
`endif

    for (int t = 0; t < 12; t++) begin
      s = AW'($urandom);
      d = AW'($urandom);
      n = LW'($urandom_range(0, 40));
      f = 1'b0;
      fd = '0;
`ifdef MEM_COPY_FILL_EN
      f = 1'($urandom_range(0, 1));
      fd = $urandom;
      fill = f;
      fill_data = fd;
`endif
      snap_model();
      model_copy(s, d, int'(n), f, fd);
      run_copy(s, d, n, dc, bc, nw, nr, nd);
      exp_cyc = f ? int'(n) + 1 : 3 * int'(n) + 1;
      check($sformatf("rnd%0d_done_cyc", t), dc, exp_cyc);
      check($sformatf("rnd%0d_reads", t), nr, f ? 0 : int'(n));
      check($sformatf("rnd%0d_writes", t), nw, int'(n));
      check_mem($sformatf("rnd%0d_mem", t));
    end
`ifdef MEM_COPY_FILL_EN
    fill = 1'b0;
`endif

    // Reset asserted during a WRITE cycle
    @(negedge clk);
    src_addr = 12'h800;
    dst_addr = 12'h900;
    length   = 13'd8;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!bus.write && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_mid_saw_write", {63'b0, bus.write}, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_cs", {63'b0, bus.chipselect}, 0);
    check("rst_mid_write", {63'b0, bus.write}, 0);
    check("rst_mid_busy", {63'b0, busy}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    w0 = wr_total + rd_total;
    repeat (30) @(negedge clk);
    check("rst_mid_no_bus", wr_total + rd_total - w0, 0);
    check("rst_mid_idle", {63'b0, busy}, 0);
    $display("reset mid-copy bus_after=%0d", wr_total + rd_total - w0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
